// File: rtl/elevator_plant_if.sv
// Controller <-> plant bus: engine/door commands one way, sensors and status back.
interface elevator_plant_if #(
    parameter int unsigned LEVEL_W = 3
);
    logic [1:0]         engine;
    logic [1:0]         door;
    logic               sensor_up;
    logic               sensor_down;
    logic [1:0]         sensor_door;
    logic [LEVEL_W-1:0] level;
    logic               at_floor;
    logic               fault;
    logic [2:0]         fault_code;

    // Controller side drives commands and observes the plant.
    modport master (
        output engine, door,
        input  sensor_up, sensor_down, sensor_door, level, at_floor, fault, fault_code
    );

    // Plant side consumes commands and reports sensors/status.
    modport slave (
        input  engine, door,
        output sensor_up, sensor_down, sensor_door, level, at_floor, fault, fault_code
    );
endinterface

// File: rtl/elevator_plant.sv
// Cabin/shaft/door plant model: N floors, configurable travel and door timing,
// mid-floor start option and sticky first-cause safety fault.
module elevator_plant #(
    parameter int unsigned FLOORS       = 8,
    parameter int unsigned LEVEL_W      = 3,
    parameter int unsigned TRAVEL_TICKS = 1000,
    parameter int unsigned DOOR_TICKS   = 300,
    parameter int unsigned START_FLOOR  = 0,
    parameter int unsigned START_HALF   = 0
) (
    input  logic            clock,
    input  logic            an_reset,
    elevator_plant_if.slave bus
);
    localparam int unsigned SUB_W  = (TRAVEL_TICKS > 2) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int unsigned DPOS_W = $clog2(DOOR_TICKS + 1);
    localparam int unsigned SUB_RST_V =
        ((START_HALF != 0) && (START_FLOOR != FLOORS - 1)) ? TRAVEL_TICKS / 2 : 0;

    localparam logic [SUB_W-1:0]   SUB_MAX   = SUB_W'(TRAVEL_TICKS - 1);
    localparam logic [SUB_W-1:0]   SUB_RST   = SUB_W'(SUB_RST_V);
    localparam logic [LEVEL_W-1:0] FLOOR_TOP = LEVEL_W'(FLOORS - 1);
    localparam logic [LEVEL_W-1:0] FLOOR_RST = LEVEL_W'(START_FLOOR);
    localparam logic [DPOS_W-1:0]  DPOS_MAX  = DPOS_W'(DOOR_TICKS);

    typedef enum logic [1:0] {
        ENG_STOP = 2'b00,
        ENG_UP   = 2'b01,
        ENG_DOWN = 2'b10,
        ENG_BAD  = 2'b11
    } engine_e;

    typedef enum logic [1:0] {
        DOOR_HOLD  = 2'b00,
        DOOR_OPEN  = 2'b01,
        DOOR_CLOSE = 2'b10,
        DOOR_BAD   = 2'b11
    } door_e;

    logic [LEVEL_W-1:0] floor_q, floor_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [DPOS_W-1:0]  dpos_q, dpos_d;
    logic               up_q, up_d;
    logic               down_q, down_d;
    logic               fault_q, fault_d;
    logic [2:0]         code_q, code_d;
    logic [2:0]         cause;
    logic               at_floor_c;

    assign at_floor_c = (sub_q == '0);

    // State register; reset discards any position in progress.
    always_ff @(posedge clock or posedge an_reset) begin
        if (an_reset) begin
            floor_q <= FLOOR_RST;
            sub_q   <= SUB_RST;
            dpos_q  <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 3'b000;
        end else begin
            floor_q <= floor_d;
            sub_q   <= sub_d;
            dpos_q  <= dpos_d;
            up_q    <= up_d;
            down_q  <= down_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // Fault detection (lowest code wins), then cabin motion and door stroke.
    always_comb begin
        floor_d = floor_q;
        sub_d   = sub_q;
        dpos_d  = dpos_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        fault_d = fault_q;
        code_d  = code_q;
        cause   = 3'b000;

        if (!fault_q) begin
            if (bus.engine == ENG_BAD || bus.door == DOOR_BAD)
                cause = 3'b001;
            else if (bus.engine == ENG_UP && floor_q == FLOOR_TOP && at_floor_c)
                cause = 3'b010;
            else if (bus.engine == ENG_DOWN && floor_q == '0 && at_floor_c)
                cause = 3'b011;
            else if (bus.engine != ENG_STOP && dpos_q != '0)
                cause = 3'b100;
            else if (bus.door == DOOR_OPEN && !at_floor_c)
                cause = 3'b101;
            else if (bus.engine != ENG_STOP && bus.door != DOOR_HOLD)
                cause = 3'b110;

            if (cause != 3'b000) begin
                // A detected fault freezes everything in the same cycle.
                fault_d = 1'b1;
                code_d  = cause;
            end else begin
                if (dpos_q == '0) begin
                    case (bus.engine)
                        ENG_UP: begin
                            if (sub_q == SUB_MAX) begin
                                floor_d = floor_q + LEVEL_W'(1);
                                sub_d   = '0;
                                up_d    = 1'b1;
                            end else begin
                                sub_d = sub_q + SUB_W'(1);
                            end
                        end
                        ENG_DOWN: begin
                            if (sub_q == SUB_W'(1)) begin
                                sub_d  = '0;
                                down_d = 1'b1;
                            end else if (sub_q == '0) begin
                                floor_d = floor_q - LEVEL_W'(1);
                                sub_d   = SUB_MAX;
                            end else begin
                                sub_d = sub_q - SUB_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end

                if (at_floor_c && bus.engine == ENG_STOP) begin
                    case (bus.door)
                        DOOR_OPEN:  if (dpos_q != DPOS_MAX) dpos_d = dpos_q + DPOS_W'(1);
                        DOOR_CLOSE: if (dpos_q != '0)       dpos_d = dpos_q - DPOS_W'(1);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Door end-stop decode is combinational from the door position.
    always_comb begin
        if (dpos_q == '0)
            bus.sensor_door = 2'b10;
        else if (dpos_q == DPOS_MAX)
            bus.sensor_door = 2'b01;
        else
            bus.sensor_door = 2'b00;
    end

    assign bus.sensor_up   = up_q;
    assign bus.sensor_down = down_q;
    assign bus.level       = floor_q;
    assign bus.at_floor    = at_floor_c;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
endmodule

// File: tb/tb_elevator_plant.sv
// Directed bench for elevator_plant: default instance plus a mid-floor-start instance.
module tb_elevator_plant;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    elevator_plant_if #(.LEVEL_W(3)) bus0 ();
    elevator_plant_if #(.LEVEL_W(3)) bus1 ();

    elevator_plant dut0 (
        .clock    (clk),
        .an_reset (rst),
        .bus      (bus0)
    );

    elevator_plant #(
        .FLOORS(8), .LEVEL_W(3), .TRAVEL_TICKS(1000), .DOOR_TICKS(300),
        .START_FLOOR(0), .START_HALF(1)
    ) dut1 (
        .clock    (clk),
        .an_reset (rst),
        .bus      (bus1)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus0.engine = 2'b00; bus0.door = 2'b00;
        bus1.engine = 2'b00; bus1.door = 2'b00;

        // Reset state
        step(3);
        chk("rst_level0",   16'(bus0.level), 16'd0);
        chk("rst_atfloor0", 16'(bus0.at_floor), 16'd1);
        chk("rst_door0",    16'(bus0.sensor_door), 16'b10);
        chk("rst_fault0",   16'(bus0.fault), 16'd0);
        chk("rst_code0",    16'(bus0.fault_code), 16'd0);
        chk("rst_up0",      16'(bus0.sensor_up), 16'd0);
        chk("rst_dn0",      16'(bus0.sensor_down), 16'd0);
        chk("rst_atfloor1", 16'(bus1.at_floor), 16'd0);
        chk("rst_level1",   16'(bus1.level), 16'd0);
        rst = 1'b0;

        // One floor up: pulse after the 1000th edge
        bus0.engine = 2'b01;
        step(999);
        chk("up999_pulse",   16'(bus0.sensor_up), 16'd0);
        chk("up999_level",   16'(bus0.level), 16'd0);
        chk("up999_atfloor", 16'(bus0.at_floor), 16'd0);
        step(1);
        chk("up1000_pulse",   16'(bus0.sensor_up), 16'd1);
        chk("up1000_level",   16'(bus0.level), 16'd1);
        chk("up1000_atfloor", 16'(bus0.at_floor), 16'd1);
        chk("up1000_fault",   16'(bus0.fault), 16'd0);
        bus0.engine = 2'b00;
        step(1);
        chk("up_pulse_single", 16'(bus0.sensor_up), 16'd0);
        chk("up_hold_level",   16'(bus0.level), 16'd1);

        // Half-floor start moving down: sub 500 -> 1 after 499 edges, 0 at edge 500
        bus1.engine = 2'b10;
        step(499);
        chk("dn499_pulse",   16'(bus1.sensor_down), 16'd0);
        chk("dn499_atfloor", 16'(bus1.at_floor), 16'd0);
        step(1);
        chk("dn500_pulse",   16'(bus1.sensor_down), 16'd1);
        chk("dn500_atfloor", 16'(bus1.at_floor), 16'd1);
        chk("dn500_level",   16'(bus1.level), 16'd0);
        bus1.engine = 2'b00;
        step(1);
        chk("dn_pulse_single", 16'(bus1.sensor_down), 16'd0);

        // Door stroke at level 0
        bus1.door = 2'b01;
        step(1);
        chk("door_open1",   16'(bus1.sensor_door), 16'b00);
        step(298);
        chk("door_open299", 16'(bus1.sensor_door), 16'b00);
        step(1);
        chk("door_open300", 16'(bus1.sensor_door), 16'b01);
        step(5);
        chk("door_open_sat",   16'(bus1.sensor_door), 16'b01);
        chk("door_open_fault", 16'(bus1.fault), 16'd0);
        bus1.door = 2'b10;
        step(299);
        chk("door_close299", 16'(bus1.sensor_door), 16'b00);
        step(1);
        chk("door_close300", 16'(bus1.sensor_door), 16'b10);

        // Move with door half open -> 100, sticky against later 001
        bus1.door = 2'b01;
        step(150);
        chk("door_half", 16'(bus1.sensor_door), 16'b00);
        bus1.door = 2'b00;
        bus1.engine = 2'b01;
        step(1);
        chk("f100_fault",   16'(bus1.fault), 16'd1);
        chk("f100_code",    16'(bus1.fault_code), 16'b100);
        chk("f100_atfloor", 16'(bus1.at_floor), 16'd1);
        chk("f100_level",   16'(bus1.level), 16'd0);
        bus1.engine = 2'b11;
        step(3);
        chk("f100_sticky", 16'(bus1.fault_code), 16'b100);
        chk("f100_door",   16'(bus1.sensor_door), 16'b00);
        bus1.engine = 2'b00;

        // Up from level 1 to 7, then top overrun
        bus0.engine = 2'b01;
        step(6000);
        chk("top_level", 16'(bus0.level), 16'd7);
        chk("top_pulse", 16'(bus0.sensor_up), 16'd1);
        chk("top_fault", 16'(bus0.fault), 16'd0);
        step(1);
        chk("f010_fault",   16'(bus0.fault), 16'd1);
        chk("f010_code",    16'(bus0.fault_code), 16'b010);
        chk("f010_level",   16'(bus0.level), 16'd7);
        chk("f010_nopulse", 16'(bus0.sensor_up), 16'd0);
        chk("f010_atfloor", 16'(bus0.at_floor), 16'd1);
        step(5);
        chk("f010_frozen",  16'(bus0.level), 16'd7);
        bus0.engine = 2'b00;

        // Async reset mid-travel at sub = 600
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        bus0.engine = 2'b01;
        step(600);
        chk("mid_atfloor", 16'(bus0.at_floor), 16'd0);
        rst = 1'b1;
        #1;
        chk("arst_level",   16'(bus0.level), 16'd0);
        chk("arst_atfloor", 16'(bus0.at_floor), 16'd1);
        chk("arst_fault",   16'(bus0.fault), 16'd0);
        chk("arst_up",      16'(bus0.sensor_up), 16'd0);
        chk("arst_code1",   16'(bus1.fault_code), 16'd0);
        chk("arst_door1",   16'(bus1.sensor_door), 16'b10);
        bus0.engine = 2'b00;
        step(2);
        rst = 1'b0;
        step(3);
        chk("post_rst_up",    16'(bus0.sensor_up), 16'd0);
        chk("post_rst_level", 16'(bus0.level), 16'd0);
        bus0.engine = 2'b01;
        step(999);
        chk("fresh999_pulse", 16'(bus0.sensor_up), 16'd0);
        step(1);
        chk("fresh_pulse", 16'(bus0.sensor_up), 16'd1);
        chk("fresh_level", 16'(bus0.level), 16'd1);

        // Door open while between floors -> 101
        step(10);
        bus0.engine = 2'b00;
        bus0.door = 2'b01;
        step(1);
        chk("f101_fault", 16'(bus0.fault), 16'd1);
        chk("f101_code",  16'(bus0.fault_code), 16'b101);
        chk("f101_level", 16'(bus0.level), 16'd1);
        bus0.door = 2'b00;

        // Same-cycle priority: 001 beats 110; engine+door both non-zero -> 110
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        bus0.engine = 2'b11; bus0.door = 2'b01;
        bus1.engine = 2'b01; bus1.door = 2'b10;
        step(1);
        chk("f001_code", 16'(bus0.fault_code), 16'b001);
        chk("f110_code", 16'(bus1.fault_code), 16'b110);
        chk("f110_atf",  16'(bus1.at_floor), 16'd0);
        bus0.engine = 2'b10; bus0.door = 2'b00;
        bus1.engine = 2'b10; bus1.door = 2'b00;
        step(2);
        chk("f001_sticky", 16'(bus0.fault_code), 16'b001);
        chk("f110_sticky", 16'(bus1.fault_code), 16'b110);
        chk("f001_level",  16'(bus0.level), 16'd0);
        chk("f110_frozen", 16'(bus1.at_floor), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
